// File: rtl/endec_pkg.sv
// ============================================================================
// Module      : endec_pkg
// Description : Shared parameters, request-frame field map and receive FSM
//               states for the convolutional encoder/decoder path.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package endec_pkg;

    localparam int MAX_CONSTRAINT_LENGTH = 9;
    localparam int MAX_CODE_RATE         = 3;
    localparam int MAX_STATE_REG_NUM     = 8;

    localparam int FRAME_BEATS = 10;
    localparam int BEAT_CNT_W  = 4;

    // Request frame field map (bit offsets within the 640-bit frame)
    localparam int GEN_POLY_W    = MAX_CONSTRAINT_LENGTH * MAX_CODE_RATE;
    localparam int GEN_POLY_LSB  = 0;
    localparam int CODE_RATE_BIT = 27;
    localparam int PRV_STATE_LSB = 28;
    localparam int ENC_DATA_LSB  = 64;
    localparam int ENC_DATA_W    = 192;
    localparam int DEC_DATA_LSB  = 256;
    localparam int DEC_DATA_W    = 384;

    typedef enum logic [1:0] {
        RECV  = 2'd0,
        HOLD  = 2'd1,
        DRAIN = 2'd2
    } rx_state_t;

endpackage

`default_nettype wire

// File: rtl/endec_axis_frame_rx.sv
// ============================================================================
// Module      : endec_axis_frame_rx
// Description : AXI4-Stream request-frame deserializer; collects ten beats,
//               checks frame length and hands the fields to the endec core.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module endec_axis_frame_rx #(
    parameter int DATA_W      = 64,
    parameter int FRAME_BEATS = 10
) (
    input  logic                                   sys_clk,
    input  logic                                   rst,
    input  logic [DATA_W-1:0]                      s_axis_tdata,
    input  logic                                   s_axis_tvalid,
    input  logic                                   s_axis_tlast,
    output logic                                   s_axis_tready,
    output logic [endec_pkg::GEN_POLY_W-1:0]        o_gen_poly_flat,
    output logic                                   o_code_rate,
    output logic [endec_pkg::MAX_STATE_REG_NUM-1:0] o_prv_encoder_state,
    output logic [endec_pkg::ENC_DATA_W-1:0]        o_encoder_data_frame,
    output logic [endec_pkg::DEC_DATA_W-1:0]        o_decoder_data_frame,
    output logic                                   o_frame_valid,
    input  logic                                   i_frame_ack,
    output logic                                   o_frame_err
);

    import endec_pkg::*;

    localparam int FRAME_W = DATA_W * FRAME_BEATS;
    // Only the low 36 bits of beat 0 carry fields; the rest is reserved
    localparam int BEAT0_W = PRV_STATE_LSB + MAX_STATE_REG_NUM;
    localparam logic [BEAT_CNT_W-1:0] c_last_beat = BEAT_CNT_W'(FRAME_BEATS - 1);

    rx_state_t               r_state;
    rx_state_t               w_state_nxt;
    logic [BEAT_CNT_W-1:0]   r_count;
    logic [BEAT_CNT_W-1:0]   w_count_nxt;
    logic                    r_tready;
    logic                    r_valid;
    logic                    r_err;
    logic                    w_err;
    logic                    w_accept;
    logic [FRAME_W-1:DATA_W] r_frame_hi;
    logic [BEAT0_W-1:0]      r_beat0;

    assign w_accept = s_axis_tvalid && r_tready;

    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_err       = 1'b0;
        case (r_state)
            RECV: begin
                if (w_accept) begin
                    if (r_count == c_last_beat) begin
                        w_count_nxt = '0;
                        if (s_axis_tlast) begin
                            w_state_nxt = HOLD;
                        end else begin
                            w_err       = 1'b1;
                            w_state_nxt = DRAIN;
                        end
                    end else if (s_axis_tlast) begin
                        w_err       = 1'b1;
                        w_count_nxt = '0;
                    end else begin
                        w_count_nxt = r_count + 1'b1;
                    end
                end
            end
            HOLD: begin
                if (i_frame_ack) begin
                    w_state_nxt = RECV;
                end
            end
            DRAIN: begin
                if (w_accept && s_axis_tlast) begin
                    w_state_nxt = RECV;
                end
            end
            default: begin
                w_state_nxt = RECV;
                w_count_nxt = '0;
            end
        endcase
    end

    // tready/valid are registered from the next state so both flip on the
    // edge that accepts the last beat or samples the ack.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            r_state    <= RECV;
            r_count    <= '0;
            r_tready   <= 1'b0;
            r_valid    <= 1'b0;
            r_err      <= 1'b0;
            r_frame_hi <= '0;
            r_beat0    <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_count  <= w_count_nxt;
            r_tready <= (w_state_nxt != HOLD);
            r_valid  <= (w_state_nxt == HOLD);
            r_err    <= w_err;
            if (r_state == RECV && w_accept) begin
                if (r_count == '0) begin
                    r_beat0 <= s_axis_tdata[BEAT0_W-1:0];
                end
                for (int k = 1; k < FRAME_BEATS; k++) begin
                    if (r_count == BEAT_CNT_W'(k)) begin
                        r_frame_hi[k*DATA_W +: DATA_W] <= s_axis_tdata;
                    end
                end
            end
        end
    end

    assign s_axis_tready        = r_tready;
    assign o_frame_valid        = r_valid;
    assign o_frame_err          = r_err;
    assign o_gen_poly_flat      = r_beat0[GEN_POLY_LSB +: GEN_POLY_W];
    assign o_code_rate          = r_beat0[CODE_RATE_BIT];
    assign o_prv_encoder_state  = r_beat0[PRV_STATE_LSB +: MAX_STATE_REG_NUM];
    assign o_encoder_data_frame = r_frame_hi[ENC_DATA_LSB +: ENC_DATA_W];
    assign o_decoder_data_frame = r_frame_hi[DEC_DATA_LSB +: DEC_DATA_W];

endmodule

`default_nettype wire

// File: tb/tb_endec_axis_frame_rx.sv
// ============================================================================
// Module      : tb_endec_axis_frame_rx
// Description : Self-checking bench for endec_axis_frame_rx with a frame
//               scoreboard and per-scenario test tasks.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_endec_axis_frame_rx;

    typedef struct packed {
        logic [26:0]  gen;
        logic         rate;
        logic [7:0]   st;
        logic [191:0] enc;
        logic [383:0] dec;
    } fields_t;

    localparam logic [26:0] NOM_POLY = 27'b100100111_110011011_111101101;
    localparam int BUDGET = 100;

    logic         sys_clk = 1'b0;
    logic         rst = 1'b1;
    logic [63:0]  s_axis_tdata = '0;
    logic         s_axis_tvalid = 1'b0;
    logic         s_axis_tlast = 1'b0;
    logic         s_axis_tready;
    logic [26:0]  o_gen_poly_flat;
    logic         o_code_rate;
    logic [7:0]   o_prv_encoder_state;
    logic [191:0] o_encoder_data_frame;
    logic [383:0] o_decoder_data_frame;
    logic         o_frame_valid;
    logic         i_frame_ack = 1'b0;
    logic         o_frame_err;

    fields_t     exp_q[$];
    logic [63:0] tx_beats [0:15];
    int          acc_cyc  [0:15];
    int          cyc = 0;
    int          err_cnt = 0;
    int          err_cyc = 0;
    int          valid_rise = 0;
    logic        prev_valid = 1'b0;
    int          ack_cyc = 0;
    int          tests = 0;
    int          fails = 0;

    endec_axis_frame_rx #(
        .DATA_W      (64),
        .FRAME_BEATS (10)
    ) dut (
        .sys_clk              (sys_clk),
        .rst                  (rst),
        .s_axis_tdata         (s_axis_tdata),
        .s_axis_tvalid        (s_axis_tvalid),
        .s_axis_tlast         (s_axis_tlast),
        .s_axis_tready        (s_axis_tready),
        .o_gen_poly_flat      (o_gen_poly_flat),
        .o_code_rate          (o_code_rate),
        .o_prv_encoder_state  (o_prv_encoder_state),
        .o_encoder_data_frame (o_encoder_data_frame),
        .o_decoder_data_frame (o_decoder_data_frame),
        .o_frame_valid        (o_frame_valid),
        .i_frame_ack          (i_frame_ack),
        .o_frame_err          (o_frame_err)
    );

    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk) cyc <= cyc + 1;

    always @(negedge sys_clk) begin
        if (o_frame_err) begin
            err_cnt <= err_cnt + 1;
            err_cyc <= cyc;
        end
        if (o_frame_valid && !prev_valid) valid_rise <= valid_rise + 1;
        prev_valid <= o_frame_valid;
    end

    // Reference model: assemble the frame from the beats, then slice fields
    function automatic fields_t model();
        logic [639:0] f;
        fields_t      r;
        for (int k = 0; k < 10; k++) f[k*64 +: 64] = tx_beats[k];
        r.gen  = f[26:0];
        r.rate = f[27];
        r.st   = f[35:28];
        r.enc  = f[255:64];
        r.dec  = f[639:256];
        return r;
    endfunction

    task automatic make_frame(input logic [26:0] gen, input logic rate, input logic [7:0] st);
        for (int i = 0; i < 16; i++) tx_beats[i] = {$urandom, $urandom};
        tx_beats[0][35:0] = {st, rate, gen};
    endtask

    task automatic drive_frame(input int n, input int last_idx, input int bmode);
        int g;
        int t;
        for (int i = 0; i < n; i++) begin
            g = 0;
            if (bmode != 0) g = (i == 4) ? 5 : int'($urandom_range(0, 2));
            for (int j = 0; j < g; j++) begin
                @(negedge sys_clk);
                s_axis_tvalid = 1'b0;
                s_axis_tlast  = 1'b0;
            end
            @(negedge sys_clk);
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = tx_beats[i];
            s_axis_tlast  = (i == last_idx);
            t = 0;
            while (!s_axis_tready && t < BUDGET) begin
                @(negedge sys_clk);
                t++;
            end
            if (t >= BUDGET) begin
                tests++;
                fails++;
                $display("FAIL drive_beat%0d: tready=%b, required 1 within %0d cycles", i, s_axis_tready, BUDGET);
            end
            acc_cyc[i] = cyc;
        end
        @(negedge sys_clk);
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    task automatic check_frame(input string name, input int ack_delay);
        fields_t e;
        int      t;
        logic    held_ok;
        t = 0;
        @(negedge sys_clk);
        while (!o_frame_valid && t < 200) begin
            @(negedge sys_clk);
            t++;
        end
        tests++;
        if (o_frame_valid !== 1'b1) begin
            fails++;
            $display("FAIL %s valid_timeout: valid=%b, required 1", name, o_frame_valid);
            return;
        end
        tests++;
        if (cyc !== acc_cyc[9] + 1) begin
            fails++;
            $display("FAIL %s valid_latency: cycle=%0d, required %0d", name, cyc, acc_cyc[9] + 1);
        end
        tests++;
        if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL %s scoreboard: queue size=0, required >0", name);
            return;
        end
        e = exp_q.pop_front();
        tests++;
        if (o_gen_poly_flat !== e.gen) begin
            fails++;
            $display("FAIL %s gen_poly: got %h, required %h", name, o_gen_poly_flat, e.gen);
        end
        tests++;
        if (o_code_rate !== e.rate) begin
            fails++;
            $display("FAIL %s code_rate: got %b, required %b", name, o_code_rate, e.rate);
        end
        tests++;
        if (o_prv_encoder_state !== e.st) begin
            fails++;
            $display("FAIL %s prv_state: got %h, required %h", name, o_prv_encoder_state, e.st);
        end
        tests++;
        if (o_encoder_data_frame !== e.enc) begin
            fails++;
            $display("FAIL %s enc_data: got %h, required %h", name, o_encoder_data_frame, e.enc);
        end
        tests++;
        if (o_decoder_data_frame !== e.dec) begin
            fails++;
            $display("FAIL %s dec_data: got %h, required %h", name, o_decoder_data_frame, e.dec);
        end
        held_ok = 1'b1;
        for (int i = 0; i < ack_delay; i++) begin
            @(negedge sys_clk);
            if (s_axis_tready !== 1'b0 || o_frame_valid !== 1'b1 ||
                o_gen_poly_flat !== e.gen || o_decoder_data_frame !== e.dec)
                held_ok = 1'b0;
        end
        tests++;
        if (held_ok !== 1'b1) begin
            fails++;
            $display("FAIL %s hold: stable=%b, required 1", name, held_ok);
        end
        i_frame_ack = 1'b1;
        ack_cyc     = cyc;
        @(negedge sys_clk);
        i_frame_ack = 1'b0;
        tests++;
        if (s_axis_tready !== 1'b1 || o_frame_valid !== 1'b0) begin
            fails++;
            $display("FAIL %s after_ack: tready=%b valid=%b, required 1 0", name, s_axis_tready, o_frame_valid);
        end
    endtask

    task automatic good_frame(input string name);
        make_frame(27'($urandom), 1'($urandom), 8'($urandom));
        exp_q.push_back(model());
        fork
            drive_frame(10, 9, 0);
            check_frame(name, 1);
        join
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge sys_clk);
        tests++;
        if (s_axis_tready !== 1'b0 || o_frame_valid !== 1'b0 || o_frame_err !== 1'b0) begin
            fails++;
            $display("FAIL reset_ctrl: tready=%b valid=%b err=%b, required 0 0 0", s_axis_tready, o_frame_valid, o_frame_err);
        end
        tests++;
        if (o_gen_poly_flat !== '0 || o_decoder_data_frame !== '0 || o_encoder_data_frame !== '0) begin
            fails++;
            $display("FAIL reset_fields: gen=%h enc=%h, required 0", o_gen_poly_flat, o_encoder_data_frame);
        end
        rst = 1'b0;
        @(negedge sys_clk);
        tests++;
        if (s_axis_tready !== 1'b1 || o_frame_valid !== 1'b0) begin
            fails++;
            $display("FAIL reset_release: tready=%b valid=%b, required 1 0", s_axis_tready, o_frame_valid);
        end
    endtask

    task automatic test_nominal();
        make_frame(NOM_POLY, 1'b1, 8'h00);
        exp_q.push_back(model());
        fork
            drive_frame(10, 9, 0);
            check_frame("nominal", 2);
        join
    endtask

    task automatic test_back_to_back();
        int b0_exp;
        b0_exp = 0;
        fork
            begin
                make_frame(NOM_POLY, 1'b1, 8'h00);
                exp_q.push_back(model());
                drive_frame(10, 9, 0);
                make_frame(27'($urandom), 1'b0, 8'($urandom));
                exp_q.push_back(model());
                drive_frame(10, 9, 0);
            end
            begin
                check_frame("b2b_first", 3);
                b0_exp = ack_cyc + 1;
                check_frame("b2b_second", 1);
            end
        join
        tests++;
        if (acc_cyc[0] !== b0_exp) begin
            fails++;
            $display("FAIL b2b_beat0_cycle: got %0d, required %0d", acc_cyc[0], b0_exp);
        end
    endtask

    task automatic test_short_frame();
        int e0;
        int v0;
        e0 = err_cnt;
        v0 = valid_rise;
        make_frame(27'($urandom), 1'b1, 8'h5a);
        drive_frame(5, 4, 0);
        repeat (3) @(negedge sys_clk);
        tests++;
        if (err_cnt - e0 !== 1) begin
            fails++;
            $display("FAIL short_err_count: got %0d, required 1", err_cnt - e0);
        end
        tests++;
        if (err_cyc !== acc_cyc[4] + 1) begin
            fails++;
            $display("FAIL short_err_cycle: got %0d, required %0d", err_cyc, acc_cyc[4] + 1);
        end
        tests++;
        if (valid_rise !== v0) begin
            fails++;
            $display("FAIL short_no_valid: valid rises=%0d, required %0d", valid_rise, v0);
        end
        good_frame("after_short");
    endtask

    task automatic test_long_frame();
        int e0;
        int v0;
        e0 = err_cnt;
        v0 = valid_rise;
        make_frame(27'($urandom), 1'b0, 8'ha5);
        drive_frame(13, 12, 0);
        repeat (3) @(negedge sys_clk);
        tests++;
        if (err_cnt - e0 !== 1) begin
            fails++;
            $display("FAIL long_err_count: got %0d, required 1", err_cnt - e0);
        end
        tests++;
        if (err_cyc !== acc_cyc[9] + 1) begin
            fails++;
            $display("FAIL long_err_cycle: got %0d, required %0d", err_cyc, acc_cyc[9] + 1);
        end
        tests++;
        if (valid_rise !== v0) begin
            fails++;
            $display("FAIL long_no_valid: valid rises=%0d, required %0d", valid_rise, v0);
        end
        good_frame("after_long");
    endtask

    task automatic test_bubbles();
        make_frame(NOM_POLY, 1'b1, 8'h00);
        exp_q.push_back(model());
        fork
            drive_frame(10, 9, 1);
            check_frame("bubbles", 1);
        join
    endtask

    task automatic test_reset_mid();
        make_frame(27'($urandom), 1'b1, 8'h11);
        drive_frame(7, 99, 0);
        rst = 1'b1;
        @(negedge sys_clk);
        tests++;
        if (s_axis_tready !== 1'b0 || o_frame_valid !== 1'b0 || o_frame_err !== 1'b0) begin
            fails++;
            $display("FAIL rst_mid_ctrl: tready=%b valid=%b err=%b, required 0 0 0", s_axis_tready, o_frame_valid, o_frame_err);
        end
        rst = 1'b0;
        good_frame("after_rst_mid");

        make_frame(27'($urandom), 1'b1, 8'h22);
        drive_frame(10, 9, 0);
        tests++;
        if (o_frame_valid !== 1'b1) begin
            fails++;
            $display("FAIL rst_hold_pre: valid=%b, required 1", o_frame_valid);
        end
        rst = 1'b1;
        @(negedge sys_clk);
        tests++;
        if (s_axis_tready !== 1'b0 || o_frame_valid !== 1'b0 ||
            o_gen_poly_flat !== '0 || o_decoder_data_frame !== '0) begin
            fails++;
            $display("FAIL rst_hold: tready=%b valid=%b gen=%h, required 0 0 0", s_axis_tready, o_frame_valid, o_gen_poly_flat);
        end
        rst = 1'b0;
        good_frame("after_rst_hold");
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_back_to_back();
        test_short_frame();
        test_long_frame();
        test_bubbles();
        test_reset_mid();
        tests++;
        if (exp_q.size() !== 0) begin
            fails++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
